// File: rtl/contador_pkg.sv
// Purpose : shared definitions for the parametrizable up/down counter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding (STOP/RUN) and SATURATE mode constants.
package contador_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } estado_t;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/detector_flanco.sv
// Purpose : registered rising-edge detector for a 1-bit level input.
// Latency : rise is combinational from din and the one-cycle registered copy.
// Backpressure: none.
// Ports   : clk, Reset (sync, active-high), din (level), rise (1 in the cycle din goes 0->1).
module detector_flanco (
  input  logic clk,
  input  logic Reset,
  input  logic din,
  output logic rise
);

  // Powers up low; during Reset the copy tracks din so that a level already
  // high at release does not look like a fresh edge.
  logic din_prev = 1'b0;

  always_ff @(posedge clk) begin
    din_prev <= din;
  end

  assign rise = din & ~din_prev & ~Reset;

endmodule

// File: rtl/contador_parametrizable.sv
// Purpose : run/stop up/down counter with load, wrap or saturate at 0..MAX_VALUE.
// Latency : count, running, tc registered (1 cycle); at_limit combinational.
// Backpressure: none; one step per enabled clk cycle while running.
// Ports   : clk, Reset (sync, active-high), enable (tick), direction (1=up),
//           start_stop (button level, rising edge toggles run/stop), load, load_value,
//           count, running, tc (terminal-count pulse), at_limit (level).
module contador_parametrizable
  import contador_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic             direction,
  input  logic             start_stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tc,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  estado_t          state      = STOP;
  estado_t          state_next;
  logic [WIDTH-1:0] count_q    = '0;
  logic             tc_q       = 1'b0;
  logic             ss_rise;
  logic             step;

  detector_flanco u_ss_edge (
    .clk   (clk),
    .Reset (Reset),
    .din   (start_stop),
    .rise  (ss_rise)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (Reset) state <= STOP;
    else       state <= state_next;
  end

  // FSM: next state, every detected edge toggles
  always_comb begin
    state_next = state;
    if (ss_rise) begin
      state_next = (state == RUN) ? STOP : RUN;
    end
  end

  // FSM: outputs (decoded from the registered state)
  always_comb begin
    running = (state == RUN);
  end

  // Limit in the direction currently requested; also decides wrap/hold on a step.
  assign at_limit = direction ? (count_q == MAX_W) : (count_q == '0);

  // The step uses the pre-toggle state, so an edge arriving together with a
  // tick starts without stepping, or stops after taking that last step.
  assign step = (state == RUN) && enable && !load;

  always_ff @(posedge clk) begin
    if (Reset) begin
      count_q <= direction ? '0 : MAX_W;
      tc_q    <= 1'b0;
    end else if (load) begin
      count_q <= (load_value > MAX_W) ? MAX_W : load_value;
      tc_q    <= 1'b0;
    end else if (step) begin
      tc_q <= at_limit;
      if (direction) begin
        if (!at_limit)                  count_q <= count_q + ONE;
        else if (SATURATE != MODE_SAT)  count_q <= '0;
      end else begin
        if (!at_limit)                  count_q <= count_q - ONE;
        else if (SATURATE != MODE_SAT)  count_q <= MAX_W;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_contador_parametrizable.sv
module tb_contador_parametrizable;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         Reset = 1'b0, enable = 1'b0, direction = 1'b0, start_stop = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count0, count1;
  logic         running0, running1, tc0, tc1, at_limit0, at_limit1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  contador_parametrizable #(.WIDTH(W), .MAX_VALUE(MAX), .SATURATE(0)) dut_wrap (
    .clk(clk), .Reset(Reset), .enable(enable), .direction(direction),
    .start_stop(start_stop), .load(load), .load_value(load_value),
    .count(count0), .running(running0), .tc(tc0), .at_limit(at_limit0));

  contador_parametrizable #(.WIDTH(W), .MAX_VALUE(MAX), .SATURATE(1)) dut_sat (
    .clk(clk), .Reset(Reset), .enable(enable), .direction(direction),
    .start_stop(start_stop), .load(load), .load_value(load_value),
    .count(count1), .running(running1), .tc(tc1), .at_limit(at_limit1));

  // Reference model: plain integer counter following the counting rules.
  int m_cnt[2];
  bit m_run[2];
  bit m_tc[2];
  bit m_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit rise;
    rise = start_stop && !m_prev;
    for (int s = 0; s < 2; s++) begin
      if (Reset) begin
        m_run[s] = 1'b0;
        m_tc[s]  = 1'b0;
        m_cnt[s] = direction ? 0 : MAX;
      end else begin
        if (load) begin
          m_cnt[s] = (int'(load_value) > MAX) ? MAX : int'(load_value);
          m_tc[s]  = 1'b0;
        end else if (m_run[s] && enable) begin
          if (direction) begin
            m_tc[s]  = (m_cnt[s] == MAX);
            m_cnt[s] = m_tc[s] ? (s == 1 ? MAX : 0) : m_cnt[s] + 1;
          end else begin
            m_tc[s]  = (m_cnt[s] == 0);
            m_cnt[s] = m_tc[s] ? (s == 1 ? 0 : MAX) : m_cnt[s] - 1;
          end
        end else begin
          m_tc[s] = 1'b0;
        end
        if (rise) m_run[s] = !m_run[s];
      end
    end
    m_prev = start_stop;
  endtask

  task automatic model_check();
    chk("wrap.count",    int'(count0),    m_cnt[0]);
    chk("wrap.running",  int'(running0),  int'(m_run[0]));
    chk("wrap.tc",       int'(tc0),       int'(m_tc[0]));
    chk("wrap.at_limit", int'(at_limit0), int'(direction ? (m_cnt[0] == MAX) : (m_cnt[0] == 0)));
    chk("sat.count",     int'(count1),    m_cnt[1]);
    chk("sat.running",   int'(running1),  int'(m_run[1]));
    chk("sat.tc",        int'(tc1),       int'(m_tc[1]));
    chk("sat.at_limit",  int'(at_limit1), int'(direction ? (m_cnt[1] == MAX) : (m_cnt[1] == 0)));
  endtask

  // One clock: inputs already applied; sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    model_check();
  endtask

  task automatic drive(input bit r, input bit e, input bit d, input bit ss, input bit ld, input int lv);
    Reset      = r;
    enable     = e;
    direction  = d;
    start_stop = ss;
    load       = ld;
    load_value = W'(lv);
  endtask

  typedef struct {
    bit rst; bit en; bit dir; bit ss; bit ld; int lv;
    int cnt; bit run; bit tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit d, bit ss, bit ld, int lv, int c, bit rn, bit t);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.ss = ss; v.ld = ld; v.lv = lv;
    v.cnt = c; v.run = rn; v.tc = t;
    return v;
  endfunction

  initial begin
    //              rst en dir ss ld lv   cnt run tc   (expected for the wrapping counter)
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,   9, 0, 0));   // reset, down -> MAX
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,   0, 0, 0));   // reset, up -> 0
    tbl.push_back(mk(0, 1, 1, 0, 1, 8,   8, 0, 0));   // load while stopped
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,   8, 1, 0));   // start edge + tick: no step
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,   9, 1, 0));   // held button, step 8->9
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,   0, 1, 1));   // wrap 9->0, tc
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,   1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 13,  9, 1, 0));   // load clamps, no step
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,   8, 1, 0));   // direction change, no lost tick
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,   7, 0, 0));   // stop edge + tick: step taken
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,   7, 0, 0));   // held button x5, ticks in STOP
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,   7, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,   7, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,   7, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,   7, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0,   7, 1, 0));   // start, no tick
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,   0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,   9, 1, 1));   // down wrap 0->9, tc
    tbl.push_back(mk(0, 1, 1, 0, 1, 5,   5, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 0));   // reset mid-run beats tick
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0, 0));   // ticks after release: held
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,   0, 1, 0));   // new edge restarts
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,   1, 1, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].ss, tbl[i].ld, tbl[i].lv);
      tick();
      chk($sformatf("vec%0d.count", i),   int'(count0),   tbl[i].cnt);
      chk($sformatf("vec%0d.running", i), int'(running0), int'(tbl[i].run));
      chk($sformatf("vec%0d.tc", i),      int'(tc0),      int'(tbl[i].tc));
    end

    // Saturating counter held at 0 going down: tc on every step at the limit.
    drive(1, 0, 0, 0, 0, 0); tick();
    chk("sat.reset_count", int'(count1), 9);
    drive(0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("sat.started", int'(running1), 1);
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("sat.step1.count", int'(count1), 0);
    chk("sat.step1.tc",    int'(tc1),    0);
    tick();
    chk("sat.step2.count", int'(count1), 0);
    chk("sat.step2.tc",    int'(tc1),    1);
    tick();
    chk("sat.step3.count", int'(count1), 0);
    chk("sat.step3.tc",    int'(tc1),    1);
    chk("sat.at_limit",    int'(at_limit1), 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("sat.tc_clear",    int'(tc1),    0);

    // Randomized traffic against the model, both counters.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 85) ? direction : ~direction,
            ($urandom_range(0, 99) < 20) ? ~start_stop : start_stop,
            ($urandom_range(0, 99) < 6),
            int'($urandom_range(0, 15)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/contador_parametrizable.md
CONTADOR_PARAMETRIZABLE -- requirements
Module: contador_parametrizable

Interface
REQ-001 Parameter WIDTH, default 4, count register width in bits (2..16).
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1, upper count limit (1..2**WIDTH-1); the count range is 0..MAX_VALUE.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  count tick from the clock divider; one step per clk cycle in which it is high.
REQ-007 direction  input  1  1 = count up, 0 = count down.
REQ-008 start_stop  input  1  push button level; each rising edge toggles run/stop.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_value  input  WIDTH  value loaded when load = 1.
REQ-011 count  output  WIDTH  current count (registered).
REQ-012 running  output  1  1 while FSM is in RUN (registered).
REQ-013 tc  output  1  terminal-count pulse, one clk wide (registered).
REQ-014 at_limit  output  1  level; 1 when count equals the limit in the current direction (MAX_VALUE if up, 0 if down).

Function
REQ-015 FSM states: STOP, RUN; STOP -> RUN and RUN -> STOP on each detected start_stop rising edge; no other transitions.
REQ-016 start_stop rising edge detected by comparison with a one-cycle registered copy; edge acts in the cycle it is detected; held level produces no further toggles.
REQ-017 Priority per cycle: Reset > load > count step > hold.
REQ-018 load = 1 (any FSM state): count <= min(load_value, MAX_VALUE) next cycle; no step taken that cycle; tc = 0.
REQ-019 Count step occurs only when state = RUN, enable = 1, load = 0.
REQ-020 Up step below MAX_VALUE: count + 1; down step above 0: count - 1.
REQ-021 Up step at MAX_VALUE: SATURATE=0 -> count <= 0, SATURATE=1 -> count held; tc = 1 next cycle in both modes.
REQ-022 Down step at 0: SATURATE=0 -> count <= MAX_VALUE, SATURATE=1 -> count held; tc = 1 next cycle in both modes.
REQ-023 tc = 0 in every cycle not following a limit step; in SATURATE=1, tc pulses again on every further enabled step at the limit.
REQ-024 direction sampled each step; a change takes effect on the next step, with no extra latency or lost ticks.
REQ-025 start_stop edge and enable in the same cycle: the step uses the state before the toggle (STOP -> RUN: no step; RUN -> STOP: step taken).
REQ-026 at_limit is combinational from registered count and the direction input; no other output is combinational.
REQ-027 Arithmetic performed in WIDTH bits; count never exceeds MAX_VALUE.

Reset
REQ-028 Reset = 1: state <= STOP; tc <= 0; edge-detect register <= current start_stop (no spurious toggle on release).
REQ-029 Reset = 1: count <= 0 if direction = 1, else count <= MAX_VALUE.
REQ-030 Reset overrides load, enable and start_stop in the same cycle; Reset mid-run returns to STOP; counting resumes only after a new start_stop edge.
REQ-031 Power-up register initial values equal the reset values.

Structure
REQ-032 Shared package contador_pkg holds the FSM state encoding (STOP = 0, RUN = 1) and the SATURATE mode constants (MODE_WRAP = 0, MODE_SAT = 1).
REQ-033 Single sub-module detector_flanco (registered rising-edge detector, 1-bit) used for start_stop; the remainder is flat.

Verification (WIDTH=4, MAX_VALUE=9)
REQ-034 Reset with direction=0 -> count=9, running=0, tc=0; Reset with direction=1 -> count=0.
REQ-035 SATURATE=0, RUN, direction=1, enable constant 1 from count=8 -> 9, 0 (tc=1 in cycle after 9->0 step), 1.
REQ-036 SATURATE=1, direction=0, count=1, three enabled steps -> 0, 0, 0; tc pulses after the 2nd and 3rd steps.
REQ-037 load=1, load_value=13 while RUN and enable=1 -> count=9 next cycle, no step, tc=0.
REQ-038 start_stop held high 5 cycles -> exactly one toggle; enable ticks during STOP leave count unchanged.
REQ-039 Reset asserted in RUN at count=5, direction=1 -> count=0, running=0; enable ticks after release leave count at 0 until a start_stop edge.
